// File: rtl/counter_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// counter_input_pkg
// Shared constants for the counter input conditioner: direction encoding,
// synchroniser depth and the preset value width, plus a small helper used to
// size the auto-repeat counter.
// Optional feature macro used elsewhere in this slice: AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
package counter_input_pkg;

  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;
  localparam int   SYNC_STAGES = 2;
  localparam int   VALUE_W     = 4;

  // Larger of two integers, for elaboration-time counter sizing.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// counter_input_conditioner_if
// Bundles the raw operator inputs and the cleaned counter controls.
//   btn_up/btn_down/btn_load : raw asynchronous buttons, active-high
//   sw_value                 : raw asynchronous preset switches
//   enable/set               : one-cycle count / load strobes
//   up_down/set_value        : direction and load value, held between strobes
// Modports: master = board/bench side, slave = conditioner side.
// -----------------------------------------------------------------------------
interface counter_input_conditioner_if;

  logic                                 btn_up;
  logic                                 btn_down;
  logic                                 btn_load;
  logic [counter_input_pkg::VALUE_W-1:0] sw_value;
  logic                                 enable;
  logic                                 up_down;
  logic                                 set;
  logic [counter_input_pkg::VALUE_W-1:0] set_value;

  modport master (
    output btn_up, btn_down, btn_load, sw_value,
    input  enable, up_down, set, set_value
  );

  modport slave (
    input  btn_up, btn_down, btn_load, sw_value,
    output enable, up_down, set, set_value
  );

endinterface

// File: rtl/counter_input_conditioner_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// One-bit conditioner: 2-flop synchroniser, stability counter and rising-edge
// press strobe.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous input
//   level    : debounced level
//   press    : one cycle high on each rising edge of level
// -----------------------------------------------------------------------------
module debounce_filter
  import counter_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   level_d;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Synchroniser shift register; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Stability counter: the level only flips after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; the counter tops out at LAST, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/counter_input_conditioner.sv
// -----------------------------------------------------------------------------
// counter_input_conditioner
// Turns raw buttons/switches into clean control strobes for the up/down counter.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : counter_input_conditioner_if.slave (raw inputs in, controls out)
// Optional feature: define AUTO_REPEAT_EN to build hold-to-repeat on up/down.
// -----------------------------------------------------------------------------
module counter_input_conditioner
  import counter_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input logic                        clk,
  input logic                        rst,
  counter_input_conditioner_if.slave bus
);

  logic up_level, up_press, down_level, down_press, load_level, load_press;
  logic [SYNC_STAGES-1:0][VALUE_W-1:0] sw_sync;
  logic [VALUE_W-1:0] sw_synced;
  logic repeat_fire, repeat_dir;
  logic enable_next, set_next, up_down_next;
  logic [VALUE_W-1:0] set_value_next;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(bus.btn_up), .level(up_level), .press(up_press)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(bus.btn_down), .level(down_level), .press(down_press)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .rst(rst), .raw(bus.btn_load), .level(load_level), .press(load_press)
  );

  // Per-bit synchronisers for the preset switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync <= '0;
    end else begin
      sw_sync <= {sw_sync[SYNC_STAGES-2:0], bus.sw_value};
    end
  end

  assign sw_synced = sw_sync[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
  localparam int               REPEAT_MAX  = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int               REP_W       = (REPEAT_MAX > 1) ? $clog2(REPEAT_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_target;
  logic             armed;
  logic             repeating;
  logic             exactly_one;
  logic             dir_press;
  logic             unused_repeat;

  assign unused_repeat = load_level;

  // Repeat fire: counter counts cycles since the initial strobe, first against
  // the delay, then against the period. Any press this cycle suppresses it.
  always_comb begin
    exactly_one = up_level ^ down_level;
    dir_press   = up_press | down_press;
    rep_target  = repeating ? PERIOD_LAST : DELAY_LAST;
    repeat_dir  = up_level ? DIR_UP : DIR_DOWN;
    repeat_fire = armed & exactly_one & ~dir_press & ~load_press & (rep_cnt == rep_target);
  end

  // Hold tracking: armed only by a fresh direction press while a single
  // direction is held, so a leftover held button never repeats unannounced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      armed     <= 1'b0;
      repeating <= 1'b0;
    end else if (!exactly_one || load_press) begin
      rep_cnt   <= '0;
      armed     <= 1'b0;
      repeating <= 1'b0;
    end else if (dir_press) begin
      rep_cnt   <= '0;
      armed     <= 1'b1;
      repeating <= 1'b0;
    end else if (!armed) begin
      rep_cnt   <= '0;
    end else if (rep_cnt == rep_target) begin
      rep_cnt   <= '0;
      repeating <= 1'b1;
    end else if (rep_cnt != {REP_W{1'b1}}) begin
      rep_cnt   <= rep_cnt + REP_W'(1);
    end else begin
      rep_cnt   <= rep_cnt;
    end
  end
`else
  logic unused_levels;

  assign repeat_fire   = 1'b0;
  assign repeat_dir    = DIR_UP;
  assign unused_levels = ^{up_level, down_level, load_level, (REPEAT_DELAY > REPEAT_PERIOD)};
`endif

  // Command decode in priority order: load, conflicting directions, up, down,
  // repeat, idle.
  always_comb begin
    enable_next    = 1'b0;
    set_next       = 1'b0;
    up_down_next   = bus.up_down;
    set_value_next = bus.set_value;
    if (load_press) begin
      set_next       = 1'b1;
      set_value_next = sw_synced;
    end else if (up_press && down_press) begin
      enable_next = 1'b0;
    end else if (up_press) begin
      enable_next  = 1'b1;
      up_down_next = DIR_UP;
    end else if (down_press) begin
      enable_next  = 1'b1;
      up_down_next = DIR_DOWN;
    end else if (repeat_fire) begin
      enable_next  = 1'b1;
      up_down_next = repeat_dir;
    end else begin
      enable_next = 1'b0;
    end
  end

  // Output registers feeding the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.enable    <= 1'b0;
      bus.set       <= 1'b0;
      bus.up_down   <= DIR_UP;
      bus.set_value <= '0;
    end else begin
      bus.enable    <= enable_next;
      bus.set       <= set_next;
      bus.up_down   <= up_down_next;
      bus.set_value <= set_value_next;
    end
  end

endmodule
